if_fetch: RTL

//  Instruction-fetch stage of the LEGv8 core. Owns the program counter and drives INST_ADDR to the

---
 rtl/legv8_pkg.sv | 17 +
 rtl/if_id_reg.sv | 39 +++
 rtl/if_fetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 front end.
// Keeps the fetch state encoding and the IF/ID payload layout in one place.
package legv8_pkg;

  localparam logic [63:0] INST_BYTES = 64'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one {pc, instr} entry plus its valid bit.
// Priority is flush > load > hold; with none of them the entry is consumed.
module if_id_reg
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [63:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [63:0] held_pc,
  output logic [31:0] held_instr
);

  if_id_t entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid       <= 1'b1;
      entry.pc    <= load_pc;
      entry.instr <= load_instr;
    end else if (!hold) begin
      // Payload is left in place after a drain; only valid qualifies it.
      valid <= 1'b0;
    end
  end

  assign held_pc    = entry.pc;
  assign held_instr = entry.instr;

endmodule

// File: rtl/if_fetch.sv
// LEGv8 instruction-fetch stage: PC, run/halt FSM, redirect and fault handling,
// and a saturating count of instructions handed to decode.
module if_fetch
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] MEM_BYTES = 64'd32
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [63:0] INST_ADDR,
  input  logic [31:0] INSTRUCTION,
  output logic        IF_VALID,
  output logic [63:0] IF_PC,
  output logic [31:0] IF_INSTR,
  input  logic        ID_READY,
  input  logic        BR_TAKEN,
  input  logic [63:0] BR_TARGET,
  output logic        HALTED,
  output logic        FAULT,
  output logic [31:0] FETCH_CNT
);

  fetch_state_t state, next_state;
  logic [63:0]  pc, next_pc;
  logic         fault, next_fault;
  logic [31:0]  fetch_cnt;
  logic [64:0]  pc_end;
  logic         fits, can_load, deliver;
  logic         reg_load, reg_flush, reg_hold;

  // Widened so a PC near 2^64 halts instead of wrapping past the limit.
  assign pc_end   = {1'b0, pc} + {1'b0, INST_BYTES};
  assign fits     = (pc_end <= {1'b0, MEM_BYTES});
  assign can_load = !IF_VALID || ID_READY;
  assign deliver  = IF_VALID && ID_READY && !BR_TAKEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      fault <= next_fault;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_fault = fault;
    reg_load   = 1'b0;
    reg_flush  = 1'b0;
    reg_hold   = !ID_READY;
    // Once faulted, redirects are ignored entirely until reset.
    if (BR_TAKEN && !fault) begin
      reg_flush = 1'b1;
      if (BR_TARGET[1:0] == 2'b00) begin
        next_pc    = BR_TARGET;
        next_state = RUN;
      end else begin
        next_fault = 1'b1;
        next_state = HALT;
      end
    end else if (state == RUN && can_load) begin
      if (fits) begin
        reg_load = 1'b1;
        next_pc  = pc + INST_BYTES;
      end else begin
        next_state = HALT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt <= '0;
    end else if (deliver && fetch_cnt != 32'hFFFF_FFFF) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (CLK),
    .rst        (RST),
    .load       (reg_load),
    .flush      (reg_flush),
    .hold       (reg_hold),
    .load_pc    (pc),
    .load_instr (INSTRUCTION),
    .valid      (IF_VALID),
    .held_pc    (IF_PC),
    .held_instr (IF_INSTR)
  );

  assign INST_ADDR = pc;
  assign HALTED    = (state == HALT);
  assign FAULT     = fault;
  assign FETCH_CNT = fetch_cnt;

endmodule
